// File: rtl/uart_baud_ctrl.sv
// Baud-rate tick generator for the UART 16750. Divides CLK by a programmable N to
// produce BAUDCE, and by N*OVERSAMPLE to produce BITCE. Divisor changes take effect
// only at period boundaries. SYNC realigns the phase to an RX start-bit edge.
//   state | meaning
//   OFF   | divisor is 0, nothing counts, waiting for a nonzero divisor write
//   RUN   | dividing by div_cur and issuing BAUDCE/BITCE ticks
module uart_baud_ctrl #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 DIV_WR,
  input  logic [DIV_WIDTH-1:0] DIV_IN,
  input  logic                 SYNC,
  output logic                 BAUDCE,
  output logic                 BITCE,
  output logic                 DIV_ACK,
  output logic                 ACTIVE,
  output logic [DIV_WIDTH-1:0] DIVISOR
);

  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0]        OVS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0]        OVS_ONE  = OW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [0:0]           OFF      = 1'b0;
  localparam logic [0:0]           RUN      = 1'b1;

  logic [0:0]           state, state_d;
  logic [DIV_WIDTH-1:0] div_cur, div_cur_d;
  logic [DIV_WIDTH-1:0] div_pend, div_pend_d;
  logic [DIV_WIDTH-1:0] cnt, cnt_d;
  logic                 pend_valid, pend_valid_d;
  logic [OW-1:0]        ovs, ovs_d;
  logic                 baud_d, bit_d, ack_d;
  logic                 terminal;
  logic                 apply;
  logic [DIV_WIDTH-1:0] apply_div;

  assign terminal = (state == RUN) && CE && (cnt == div_cur - DIV_ONE);

  always_comb begin
    state_d      = state;
    div_cur_d    = div_cur;
    div_pend_d   = div_pend;
    pend_valid_d = pend_valid;
    cnt_d        = cnt;
    ovs_d        = ovs;
    baud_d       = 1'b0;
    bit_d        = 1'b0;
    ack_d        = 1'b0;
    apply        = 1'b0;
    apply_div    = div_pend;

    if (state == OFF) begin
      if (DIV_WR) begin
        div_cur_d    = DIV_IN;
        cnt_d        = '0;
        ovs_d        = '0;
        pend_valid_d = 1'b0;
        ack_d        = 1'b1;
        if (DIV_IN != '0) state_d = RUN;
      end
    end else begin
      if (SYNC || terminal) begin
        // Period boundary: a same-cycle write overrides any older pending divisor.
        cnt_d = '0;
        apply = DIV_WR || pend_valid;
        if (DIV_WR) apply_div = DIV_IN;
        if (SYNC) begin
          ovs_d = '0;
        end else begin
          baud_d = 1'b1;
          if (ovs == OVS_LAST) begin
            bit_d = 1'b1;
            ovs_d = '0;
          end else begin
            ovs_d = ovs + OVS_ONE;
          end
        end
      end else begin
        if (CE) cnt_d = cnt + DIV_ONE;
        if (DIV_WR) begin
          div_pend_d   = DIV_IN;
          pend_valid_d = 1'b1;
        end
      end

      if (apply) begin
        div_cur_d    = apply_div;
        pend_valid_d = 1'b0;
        ack_d        = 1'b1;
        if (apply_div == '0) begin
          state_d = OFF;
          ovs_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= OFF;
      div_cur    <= '0;
      div_pend   <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
      ovs        <= '0;
      BAUDCE     <= 1'b0;
      BITCE      <= 1'b0;
      DIV_ACK    <= 1'b0;
    end else begin
      state      <= state_d;
      div_cur    <= div_cur_d;
      div_pend   <= div_pend_d;
      pend_valid <= pend_valid_d;
      cnt        <= cnt_d;
      ovs        <= ovs_d;
      BAUDCE     <= baud_d;
      BITCE      <= bit_d;
      DIV_ACK    <= ack_d;
    end
  end

  assign ACTIVE  = (state == RUN);
  assign DIVISOR = div_cur;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Bench for uart_baud_ctrl: directed scenarios plus random traffic, every cycle
// compared against a remaining-cycles / tick-count reference model.
module tb_uart_baud_ctrl;
  localparam int DW  = 8;
  localparam int OVS = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CE;
  logic          DIV_WR;
  logic [DW-1:0] DIV_IN;
  logic          SYNC;
  logic          BAUDCE, BITCE, DIV_ACK, ACTIVE;
  logic [DW-1:0] DIVISOR;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: divisor in effect, pending write (-1 = none), CE cycles left
  // in the current period, and BAUDCE ticks since the last phase restart.
  bit m_run;
  int m_n, m_pend, m_left, m_nbaud;
  bit e_baud, e_bit, e_ack;

  always #5 CLK = ~CLK;

  uart_baud_ctrl #(.DIV_WIDTH(DW), .OVERSAMPLE(OVS)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .DIV_WR(DIV_WR), .DIV_IN(DIV_IN), .SYNC(SYNC),
    .BAUDCE(BAUDCE), .BITCE(BITCE), .DIV_ACK(DIV_ACK), .ACTIVE(ACTIVE), .DIVISOR(DIVISOR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_n = 0; m_pend = -1; m_left = 0; m_nbaud = 0;
    e_baud = 0; e_bit = 0; e_ack = 0;
  endtask

  task automatic model_apply(input int d);
    m_n = d; m_pend = -1; e_ack = 1; m_left = d;
    if (d == 0) begin
      m_run = 0;
      m_nbaud = 0;
    end
  endtask

  task automatic model_step(input bit ce, input bit wr, input int din, input bit sy);
    e_baud = 0; e_bit = 0; e_ack = 0;
    if (!m_run) begin
      if (wr) begin
        m_n = din; m_left = din; m_nbaud = 0; m_pend = -1; e_ack = 1;
        m_run = (din != 0);
      end
    end else if (sy) begin
      m_left = m_n; m_nbaud = 0;
      if (wr) model_apply(din);
      else if (m_pend >= 0) model_apply(m_pend);
    end else if (ce && m_left == 1) begin
      e_baud = 1;
      m_nbaud++;
      e_bit = (m_nbaud % OVS == 0);
      m_left = m_n;
      if (wr) model_apply(din);
      else if (m_pend >= 0) model_apply(m_pend);
    end else begin
      if (ce) m_left--;
      if (wr) m_pend = din;
    end
  endtask

  task automatic compare_all();
    check("baudce",  BAUDCE,  e_baud);
    check("bitce",   BITCE,   e_bit);
    check("div_ack", DIV_ACK, e_ack);
    check("active",  ACTIVE,  m_run);
    check("divisor", DIVISOR, m_n);
  endtask

  task automatic step();
    bit ce_s, wr_s, sy_s;
    int d_s;
    ce_s = CE; wr_s = DIV_WR; sy_s = SYNC; d_s = int'(DIV_IN);
    @(posedge CLK);
    model_step(ce_s, wr_s, d_s, sy_s);
    #1;
    compare_all();
  endtask

  task automatic wr(input int d);
    DIV_WR = 1'b1; DIV_IN = DW'(d);
    step();
    DIV_WR = 1'b0;
  endtask

  task automatic steps_to_baud(input int max_steps, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!BAUDCE && n < max_steps);
    check("baud_seen", BAUDCE, 1);
  endtask

  initial begin
    int n, nb, first_baud, first_bit;
    int ticks[$];
    RST = 1'b1; CE = 1'b0; DIV_WR = 1'b0; DIV_IN = '0; SYNC = 1'b0;
    model_reset();
    #12 RST = 1'b0;
    compare_all();

    // Idle after reset: nothing happens without a divisor
    CE = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Load N=3 from OFF
    wr(3);
    check("load_ack", DIV_ACK, 1);
    check("load_active", ACTIVE, 1);
    first_baud = -1; first_bit = -1; nb = 0;
    for (int k = 2; k <= 55; k++) begin
      step();
      if (BAUDCE) begin
        nb++;
        if (first_baud < 0) first_baud = k;
      end
      if (BITCE && first_bit < 0) first_bit = k;
    end
    check("first_baud", first_baud, 4);
    check("first_bit", first_bit, 49);
    check("baud_count", nb, 18);

    // Runtime change 3 -> 5, then two writes 5, 7 in one period
    steps_to_baud(10, n);
    wr(5);
    steps_to_baud(10, n);
    check("old_period_len", n, 2);
    check("change_ack", DIV_ACK, 1);
    check("change_div", DIVISOR, 5);
    wr(5);
    wr(7);
    steps_to_baud(10, n);
    check("last_write_wins", DIVISOR, 7);
    steps_to_baud(20, n);
    check("new_period_len", n, 7);

    // Divisor 0 stops the generator after the final tick; 2 restarts it
    wr(0);
    steps_to_baud(20, n);
    check("stop_ack", DIV_ACK, 1);
    check("stop_active", ACTIVE, 0);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (BAUDCE) nb++;
    end
    check("off_no_ticks", nb, 0);
    wr(2);
    steps_to_baud(10, n);
    check("restart_latency", n + 1, 3);

    // N=4, SYNC on a terminal cycle
    wr(4);
    steps_to_baud(10, n);
    check("n4_div", DIVISOR, 4);
    for (int i = 0; i < 3; i++) step();
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    check("sync_no_tick", BAUDCE, 0);
    steps_to_baud(10, n);
    check("sync_next_tick", n, 4);
    nb = 1;
    while (!BITCE && nb < 20) begin
      steps_to_baud(10, n);
      nb++;
    end
    check("sync_bit_after", nb, 16);

    // N=2 with CE toggling
    wr(2);
    steps_to_baud(10, n);
    check("n2_div", DIVISOR, 2);
    for (int i = 0; i < 24; i++) begin
      CE = (i % 2 == 0);
      step();
      if (BAUDCE) ticks.push_back(i);
    end
    if (ticks.size() >= 3) check("ce_toggle_period", ticks[2] - ticks[1], 4);
    else check("ce_toggle_ticks", ticks.size(), 3);

    // Async reset mid-period
    CE = 1'b1;
    step();
    #2 RST = 1'b1;
    #1;
    check("rst_baudce", BAUDCE, 0);
    check("rst_bitce", BITCE, 0);
    check("rst_ack", DIV_ACK, 0);
    check("rst_active", ACTIVE, 0);
    check("rst_divisor", DIVISOR, 0);
    model_reset();
    #2 RST = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Maximum divisor
    wr((1 << DW) - 1);
    steps_to_baud(300, n);
    check("max_div_period", n, (1 << DW) - 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      CE = ($urandom_range(0, 3) != 0);
      SYNC = ($urandom_range(0, 24) == 0);
      DIV_WR = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 15);
      DIV_IN = (r == 0) ? DW'(0) : DW'((r % 6) + 1);
      step();
    end
    DIV_WR = 1'b0; SYNC = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
